vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
//  Generates 640x480@60 VGA timing on the dot clock and scans a packed 3-bit RGB framebuffer out of VRAM.
//  Sits directly downstream of vram: drives its video-side read address and consumes the read data.
//  Drives the top-level r/g/b/hsync/vsync pins and gives the CPU a vblank level.
//  Framebuffer: 320x240 logical pixels, each doubled horizontally and vertically; 2 pixels/byte, 160 bytes/row.
// PARAMETERS
//  H_ACTIVE        640      visible dots per line
//  H_FP            16       horizontal front porch, dots
//  H_SYNC          96       hsync pulse width, dots
//  H_BP            48       horizontal back porch, dots (H_TOTAL = 800)
//  V_ACTIVE        480      visible lines
//  V_FP            10       vertical front porch, lines
//  V_SYNC          2        vsync pulse width, lines
//  V_BP            33       vertical back porch, lines (V_TOTAL = 525)
//  BASE_ADDR       16'h0000 VRAM address of logical row 0, byte 0
//  BYTES_PER_LINE  160      VRAM bytes per logical row
// PORTS
//  clk        in   1   dot clock (25.175 MHz); all logic on posedge
//  reset      in   1   asynchronous, active-high reset
//  vram_addr  out  16  VRAM video-port read address (registered)
//  vram_data  in   8   VRAM read data; valid 1 clk after vram_addr
//  r          out  1   red pixel (registered)
//  g          out  1   green pixel (registered)
//  b          out  1   blue pixel (registered)
//  hsync      out  1   horizontal sync, active-low (registered)
//  vsync      out  1   vertical sync, active-low (registered)
//  vblank     out  1   1 while v_count >= V_ACTIVE (registered from counters)
// BEHAVIOUR
//  Reset values:
//   - h_count=0, v_count=0, row_base=BASE_ADDR, vram_addr=BASE_ADDR.
//   - r=g=b=0, hsync=vsync=1, vblank=0; all pipeline delay regs cleared to blank/inactive.
//  Counters:
//   - h_count 0..799, increments every clk; wraps to 0 after 799.
//   - v_count increments when h_count wraps; wraps 524->0.
//  Stages (3-stage pipeline):
//   - S0: counters.
//   - S1: vram_addr registered. Active: row_base + h_count[9:2]. Blank: row_base (data ignored).
//   - S2: vram_data valid.
//   - S3: r/g/b/hsync/vsync registered.
//   - Fixed latency L=3: counter state at cycle n appears on pins at cycle n+3. Sync timing shares this latency.
//  Pixel select at S3 uses h_count[1] delayed 2 clks:
//   - 0 -> {r,g,b}=vram_data[2:0]; 1 -> vram_data[6:4]. Bits 3 and 7 are ignored.
//   - Active dot decode is delayed alongside; r/g/b forced 0 outside h<640 && v<480.
//  Sync decode:
//   - hsync=0 for h_count in [656,752).
//   - vsync=0 for v_count in [490,492); vsync changes at h_count wrap.
//  row_base updates at h_count==799 only:
//   - v_count==524 -> BASE_ADDR (takes priority).
//   - else v_count<480 && v_count[0]==1 -> row_base + BYTES_PER_LINE.
//   - else hold. Each logical row is fetched on two consecutive lines (vertical doubling).
//  Address arithmetic: 16-bit, wraps mod 2^16. No saturation.
//  No CPU handshake. vram is dual-ported, so scanout never stalls and never requests/acks.
//  Reset mid-frame: outputs take their reset values asynchronously. After release, scan restarts at (0,0) with row_base=BASE_ADDR.
// TESTING
//  1. Timing, after reset release:
//     - hsync falling edges 800 clks apart; hsync low for 96 clks.
//     - vsync low for 1600 clks; frame period 420000 clks.
//     - vblank high for 45*800 clks per frame.
//  2. Pixel packing, VRAM model mem[0]=8'h61, 1-clk read latency:
//     - First active dots 0-1 give {r,g,b}=001.
//     - Dots 2-3 give 110.
//     - First active dot appears 3 clks after counters reach (0,0).
//  3. Line doubling:
//     - Lines 0 and 1 fetch addresses 0..159.
//     - Line 2 starts at 160.
//     - Line 479 ends at 38399.
//     - No fetch address exceeds 38399 during active video.
//  4. Blanking: vram_data tied to 8'hFF -> r=g=b=1 exactly inside the 640x480 window (shifted by L=3), 0 everywhere else.
//  5. Reset mid-frame at v=100,h=300:
//     - Pins go to reset values with no clk edge.
//     - After release, first hsync falling edge occurs 656+3 clks later.
//  6. BASE_ADDR=16'h1000:
//     - Frame 1 line 0 fetches 0x1000..0x109F.
//     - After v wrap, frame 2 line 0 again starts at 0x1000.

Source files
------------

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - 640x480 VGA timing generator and packed 3-bit RGB framebuffer scanout
// Counters (S0) -> VRAM address (S1) -> VRAM data (S2) -> pins (S3); every pin lags the counters by 3 clks.
module vga_scanout #(
   parameter int          H_ACTIVE       = 640,
   parameter int          H_FP           = 16,
   parameter int          H_SYNC         = 96,
   parameter int          H_BP           = 48,
   parameter int          V_ACTIVE       = 480,
   parameter int          V_FP           = 10,
   parameter int          V_SYNC         = 2,
   parameter int          V_BP           = 33,
   parameter logic [15:0] BASE_ADDR      = 16'h0000,
   parameter int          BYTES_PER_LINE = 160
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] vram_addr,
   input  logic [7:0]  vram_data,
   output logic        r,
   output logic        g,
   output logic        b,
   output logic        hsync,
   output logic        vsync,
   output logic        vblank
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0]  HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [15:0] LINE_STEP  = 16'(BYTES_PER_LINE);

   // S0: raster counters and the VRAM address of the current logical row
   logic [9:0]  h_count;
   logic [9:0]  v_count;
   logic [15:0] row_base;

   logic h_wrap;
   logic v_wrap;
   logic active0;
   logic hs0;
   logic vs0;

   assign h_wrap  = (h_count == H_LAST);
   assign v_wrap  = (v_count == V_LAST);
   assign active0 = (h_count < H_ACT) && (v_count < V_ACT);
   assign hs0     = !((h_count >= HS_START) && (h_count < HS_END));
   assign vs0     = !((v_count >= VS_START) && (v_count < VS_END));

   // Odd visible lines advance the row so each logical row is shown on two lines
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_count  <= '0;
         v_count  <= '0;
         row_base <= BASE_ADDR;
      end else if (h_wrap) begin
         h_count <= '0;
         v_count <= v_wrap ? 10'd0 : v_count + 10'd1;
         if (v_wrap)
            row_base <= BASE_ADDR;
         else if ((v_count < V_ACT) && v_count[0])
            row_base <= row_base + LINE_STEP;
      end else begin
         h_count <= h_count + 10'd1;
      end
   end

   // S1: address issue plus the decodes that must travel alongside the fetch
   logic sel1;
   logic act1;
   logic hs1;
   logic vs1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vram_addr <= BASE_ADDR;
         sel1      <= 1'b0;
         act1      <= 1'b0;
         hs1       <= 1'b1;
         vs1       <= 1'b1;
         vblank    <= 1'b0;
      end else begin
         vram_addr <= active0 ? row_base + {8'h00, h_count[9:2]} : row_base;
         sel1      <= h_count[1];
         act1      <= active0;
         hs1       <= hs0;
         vs1       <= vs0;
         vblank    <= (v_count >= V_ACT);
      end
   end

   // S2: vram_data for the S1 address is valid during this stage
   logic sel2;
   logic act2;
   logic hs2;
   logic vs2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel2 <= 1'b0;
         act2 <= 1'b0;
         hs2  <= 1'b1;
         vs2  <= 1'b1;
      end else begin
         sel2 <= sel1;
         act2 <= act1;
         hs2  <= hs1;
         vs2  <= vs1;
      end
   end

   // S3: low nibble is the even logical pixel, high nibble the odd one
   logic [2:0] pix;
   logic       unused_data_bits;

   assign pix              = sel2 ? vram_data[6:4] : vram_data[2:0];
   assign unused_data_bits = vram_data[7] ^ vram_data[3];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r     <= 1'b0;
         g     <= 1'b0;
         b     <= 1'b0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         {r, g, b} <= act2 ? pix : 3'b000;
         hsync     <= hs2;
         vsync     <= vs2;
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - scoreboard bench for vga_scanout with a reduced vertical raster
// Frame is 800 x 15 lines (8 active) so two frames plus a mid-frame reset stay short.
module tb_vga_scanout;

   localparam logic [15:0] BASE = 16'h1000;
   localparam int S_RGB = 0, S_HS = 1, S_VS = 2, S_VB = 3, S_ADDR = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] vram_addr;
   logic [7:0]  vram_data = 8'h00;
   logic        r, g, b, hsync, vsync, vblank;

   logic [7:0]  mem [0:65535];
   int          cyc;
   int          total = 0;
   int          bad = 0;
   bit          flush = 1'b0;
   event        chk_now;

   typedef struct {
      int          cyc;
      int          sig;
      logic [15:0] exp;
      string       name;
   } chk_t;

   chk_t sb[$];

   vga_scanout #(
      .V_ACTIVE (8),
      .V_FP     (2),
      .V_SYNC   (2),
      .V_BP     (3),
      .BASE_ADDR(BASE)
   ) dut (
      .clk      (clk),
      .reset    (rst),
      .vram_addr(vram_addr),
      .vram_data(vram_data),
      .r        (r),
      .g        (g),
      .b        (b),
      .hsync    (hsync),
      .vsync    (vsync),
      .vblank   (vblank)
   );

   always #5 clk = ~clk;

   always @(posedge clk) vram_data <= mem[vram_addr];

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic push(input int c, input int s, input logic [15:0] e, input string n);
      chk_t t;
      t.cyc  = c;
      t.sig  = s;
      t.exp  = e;
      t.name = n;
      sb.push_back(t);
   endtask

   function automatic logic [15:0] sample(input int s);
      case (s)
         S_RGB:   return {13'd0, r, g, b};
         S_HS:    return {15'd0, hsync};
         S_VS:    return {15'd0, vsync};
         S_VB:    return {15'd0, vblank};
         default: return vram_addr;
      endcase
   endfunction

   // cyc < 0 entries are checked on the next trigger, others at the negedge of their cycle
   initial begin
      chk_t        e;
      logic [15:0] act;
      bit          go;
      forever begin
         @(negedge clk or chk_now);
         go = 1'b1;
         while (go && sb.size() > 0) begin
            e = sb[0];
            if (flush) begin
               void'(sb.pop_front());
               total++;
               bad++;
               $display("FAIL %s: never reached, cycle %0d required", e.name, e.cyc);
            end else if (e.cyc < 0 || (!rst && e.cyc <= cyc)) begin
               void'(sb.pop_front());
               total++;
               if (e.cyc >= 0 && e.cyc < cyc) begin
                  bad++;
                  $display("FAIL %s: missed cycle %0d, now %0d", e.name, e.cyc, cyc);
               end else begin
                  act = sample(e.sig);
                  if (act !== e.exp) begin
                     bad++;
                     $display("FAIL %s @cyc %0d: got %0h required %0h", e.name, e.cyc, act, e.exp);
                  end
               end
            end else begin
               go = 1'b0;
            end
         end
      end
   end

   task automatic push_reset_state(input string tag);
      push(-1, S_RGB,  16'h0,  {tag, "_rgb"});
      push(-1, S_HS,   16'h1,  {tag, "_hsync"});
      push(-1, S_VS,   16'h1,  {tag, "_vsync"});
      push(-1, S_VB,   16'h0,  {tag, "_vblank"});
      push(-1, S_ADDR, BASE,   {tag, "_addr"});
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h1000] = 8'h61;   // row 0 byte 0
      mem[16'h1001] = 8'h43;   // row 0 byte 1
      mem[16'h109F] = 8'h70;   // row 0 last byte
      mem[16'h10A0] = 8'h75;   // row 1 byte 0
      mem[16'h118A] = 8'h77;   // row 2 byte 74
      mem[16'h127F] = 8'h30;   // row 3 last byte
      mem[16'h1280] = 8'h77;   // fetched during vblank, must stay dark

      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      push_reset_state("reset");
      ->chk_now;
      #1;

      push(0,     S_ADDR, 16'h1000, "addr_c0");
      push(1,     S_ADDR, 16'h1000, "addr_first_fetch");
      push(2,     S_RGB,  16'h0,    "rgb_before_latency");
      push(2,     S_HS,   16'h1,    "hsync_before_latency");
      push(3,     S_RGB,  16'h1,    "rgb_dot0");
      push(4,     S_RGB,  16'h1,    "rgb_dot1");
      push(5,     S_ADDR, 16'h1001, "addr_h4");
      push(5,     S_RGB,  16'h6,    "rgb_dot2");
      push(6,     S_RGB,  16'h6,    "rgb_dot3");
      push(7,     S_RGB,  16'h3,    "rgb_dot4");
      push(9,     S_RGB,  16'h4,    "rgb_dot6");
      push(640,   S_ADDR, 16'h109F, "addr_line0_end");
      push(641,   S_ADDR, 16'h1000, "addr_hblank");
      push(642,   S_RGB,  16'h7,    "rgb_dot639");
      push(643,   S_RGB,  16'h0,    "rgb_dot640_blank");
      push(658,   S_HS,   16'h1,    "hsync_h655");
      push(659,   S_HS,   16'h0,    "hsync_fall");
      push(754,   S_HS,   16'h0,    "hsync_h751");
      push(755,   S_HS,   16'h1,    "hsync_rise");
      push(801,   S_ADDR, 16'h1000, "addr_line1_start");
      push(803,   S_RGB,  16'h1,    "rgb_line1_dot0");
      push(1440,  S_ADDR, 16'h109F, "addr_line1_end");
      push(1459,  S_HS,   16'h0,    "hsync_fall_line1");
      push(1601,  S_ADDR, 16'h10A0, "addr_line2_start");
      push(1603,  S_RGB,  16'h5,    "rgb_line2_dot0");
      push(1605,  S_RGB,  16'h7,    "rgb_line2_dot2");
      push(6240,  S_ADDR, 16'h127F, "addr_last_active");
      push(6242,  S_RGB,  16'h3,    "rgb_last_dot");
      push(6243,  S_RGB,  16'h0,    "rgb_after_last_dot");
      push(6400,  S_VB,   16'h0,    "vblank_last_active");
      push(6401,  S_VB,   16'h1,    "vblank_rise");
      push(6401,  S_ADDR, 16'h1280, "addr_vblank_row");
      push(6403,  S_RGB,  16'h0,    "rgb_vblank_dark");
      push(8002,  S_VS,   16'h1,    "vsync_v9");
      push(8003,  S_VS,   16'h0,    "vsync_fall");
      push(9602,  S_VS,   16'h0,    "vsync_v11");
      push(9603,  S_VS,   16'h1,    "vsync_rise");
      push(12000, S_VB,   16'h1,    "vblank_v14");
      push(12001, S_VB,   16'h0,    "vblank_fall");
      push(12001, S_ADDR, 16'h1000, "addr_frame2_start");
      push(12003, S_RGB,  16'h1,    "rgb_frame2_dot0");
      push(12659, S_HS,   16'h0,    "hsync_fall_frame2");
      push(16300, S_ADDR, 16'h118A, "addr_before_reset");
      push(16300, S_RGB,  16'h7,    "rgb_before_reset");

      @(posedge clk);
      #2 rst = 1'b0;

      while (cyc < 16300) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      push_reset_state("async_reset");
      ->chk_now;
      #1;

      push(1,   S_ADDR, 16'h1000, "addr_restart");
      push(3,   S_RGB,  16'h1,    "rgb_restart_dot0");
      push(658, S_HS,   16'h1,    "hsync_restart_h655");
      push(659, S_HS,   16'h0,    "hsync_restart_fall");

      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      while (cyc < 700) @(negedge clk);
      repeat (4) @(negedge clk);
      #1;
      flush = 1'b1;
      ->chk_now;
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
